// File: rtl/mips_mem_arbiter.sv
// Single-port RAM arbiter for pipe_MIPS32: shares one synchronous RAM between
// instruction fetch, the MEM-stage data port and a debug/loader port.
module mips_mem_arbiter #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          halted,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int SCW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_DM, TAG_DBG} tag_t;

   tag_t           rtag_q, rtag_d;
   logic [SCW-1:0] sc_q, sc_d;
   logic           starve;

   // Grants are masked while reset is held so the RAM never sees a stray access.
   always_comb begin
      if_gnt  = 1'b0;
      dm_gnt  = 1'b0;
      dbg_gnt = 1'b0;
      starve  = !halted && if_req && (sc_q == SCW'(STARVE_MAX));
      if (rst_n) begin
         if (halted) begin
            if (dbg_req)     dbg_gnt = 1'b1;
            else if (dm_req) dm_gnt  = 1'b1;
            else if (if_req) if_gnt  = 1'b1;
         end else begin
            if (starve)       if_gnt  = 1'b1;
            else if (dm_req)  dm_gnt  = 1'b1;
            else if (if_req)  if_gnt  = 1'b1;
            else if (dbg_req) dbg_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_en   = 1'b1;
         mem_addr = if_addr;
      end else if (dm_gnt) begin
         mem_en    = 1'b1;
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (dbg_gnt) begin
         mem_en    = 1'b1;
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   always_comb begin
      rtag_d = TAG_NONE;
      if (if_gnt)                 rtag_d = TAG_IF;
      else if (dm_gnt && !dm_we)  rtag_d = TAG_DM;
      else if (dbg_gnt && !dbg_we) rtag_d = TAG_DBG;
   end

   // Saturates so a long halted stretch cannot wrap sc past the override point.
   always_comb begin
      sc_d = sc_q;
      if (!if_req || if_gnt)
         sc_d = '0;
      else if (dm_gnt && (sc_q != SCW'(STARVE_MAX)))
         sc_d = sc_q + SCW'(1);
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         rtag_q <= TAG_NONE;
         sc_q   <= '0;
      end else begin
         rtag_q <= rtag_d;
         sc_q   <= sc_d;
      end
   end

   assign if_rvalid  = (rtag_q == TAG_IF);
   assign dm_rvalid  = (rtag_q == TAG_DM);
   assign dbg_rvalid = (rtag_q == TAG_DBG);
   assign busy       = (rtag_q != TAG_NONE);
   assign rdata      = busy ? mem_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural synchronous RAM attached.
module tb_mips_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk1 = 1'b0;
   logic          rst_n;
   logic          halted;
   logic          if_req, dm_req, dm_we, dbg_req, dbg_we;
   logic [AW-1:0] if_addr, dm_addr, dbg_addr;
   logic [DW-1:0] dm_wdata, dbg_wdata;
   logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] rdata;
   logic          mem_en, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] ram [0:(1<<AW)-1];

   always #5 clk1 = ~clk1;

   mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
      .clk1(clk1), .rst_n(rst_n), .halted(halted),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = 32'hA000_0000 + i;
   end

   always @(posedge clk1) begin
      if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata     <= ram[mem_addr];
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk1);
      #1;
   endtask

   task automatic settle;
      @(negedge clk1);
   endtask

   logic [9:0] exp_if_pat;

   initial begin
      rst_n = 1'b0; halted = 1'b0;
      if_req = 1'b1; dm_req = 1'b1; dbg_req = 1'b1; dm_we = 1'b1; dbg_we = 1'b1;
      if_addr = 10'h3FF; dm_addr = 10'h155; dbg_addr = 10'h2AA;
      dm_wdata = 32'hFFFF_FFFF; dbg_wdata = 32'h1234_5678;

      // Reset held with every request high
      settle;
      check_eq("rst_gnts",   {if_gnt, dm_gnt, dbg_gnt}, 0);
      check_eq("rst_rvalid", {if_rvalid, dm_rvalid, dbg_rvalid}, 0);
      check_eq("rst_mem",    {mem_en, mem_we, busy}, 0);
      check_eq("rst_addr",   mem_addr, 0);
      check_eq("rst_wdata",  mem_wdata, 0);
      check_eq("rst_rdata",  rdata, 0);
      $display("reset held: gnts=%b mem_en=%b busy=%b", {if_gnt, dm_gnt, dbg_gnt}, mem_en, busy);
      #1;
      if_req = 1'b0; dm_req = 1'b0; dbg_req = 1'b0; dm_we = 1'b0; dbg_we = 1'b0;
      rst_n = 1'b1;
      settle;
      check_eq("idle_en", mem_en, 0);
      check_eq("idle_busy", busy, 0);
      $display("idle after release: mem_en=%b busy=%b", mem_en, busy);

      // Debug write then read-back of address 5
      next_cycle;
      halted = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd5; dbg_wdata = 32'h2802_0014;
      settle;
      check_eq("dbgw_gnt", dbg_gnt, 1);
      check_eq("dbgw_port", {mem_en, mem_we}, 2'b11);
      check_eq("dbgw_addr", mem_addr, 5);
      check_eq("dbgw_wdata", mem_wdata, 32'h2802_0014);
      $display("dbg write addr=%0d data=%h gnt=%b", mem_addr, mem_wdata, dbg_gnt);
      next_cycle;
      dbg_we = 1'b0;
      settle;
      check_eq("dbgr_gnt", dbg_gnt, 1);
      check_eq("dbgr_we", mem_we, 0);
      check_eq("dbgr_busy", busy, 0);
      $display("dbg read addr=%0d gnt=%b", mem_addr, dbg_gnt);
      next_cycle;
      dbg_req = 1'b0;
      settle;
      check_eq("dbgr_rvalid", dbg_rvalid, 1);
      check_eq("dbgr_rdata", rdata, 32'h2802_0014);
      check_eq("dbgr_busy2", busy, 1);
      check_eq("dbgr_other", {if_rvalid, dm_rvalid, mem_en}, 0);
      $display("dbg read resp rvalid=%b rdata=%h", dbg_rvalid, rdata);

      // Running mode: dm beats if, if follows
      next_cycle;
      halted = 1'b0; if_req = 1'b1; if_addr = 10'd7; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd9;
      settle;
      check_eq("prio_gnt", {if_gnt, dm_gnt, dbg_gnt}, 3'b010);
      $display("prio: if_gnt=%b dm_gnt=%b", if_gnt, dm_gnt);
      next_cycle;
      dm_req = 1'b0;
      settle;
      check_eq("prio_if_gnt", if_gnt, 1);
      check_eq("prio_if_addr", mem_addr, 7);
      check_eq("prio_dm_rvalid", dm_rvalid, 1);
      check_eq("prio_dm_rdata", rdata, 32'hA000_0009);
      $display("prio: if_gnt=%b dm_rvalid=%b rdata=%h", if_gnt, dm_rvalid, rdata);
      next_cycle;
      if_req = 1'b0;
      settle;
      check_eq("prio_if_rvalid", {if_rvalid, dm_rvalid}, 2'b10);
      check_eq("prio_if_rdata", rdata, 32'hA000_0007);
      $display("prio: if_rvalid=%b rdata=%h", if_rvalid, rdata);

      // Starvation: 4 dm grants then 1 if grant, twice
      next_cycle;
      dm_req = 1'b1; dm_addr = 10'd20; if_req = 1'b1; if_addr = 10'd21;
      exp_if_pat = 10'b10000_10000;
      for (int i = 0; i < 10; i++) begin
         settle;
         check_eq($sformatf("starve_if_gnt[%0d]", i), if_gnt, exp_if_pat[i]);
         check_eq($sformatf("starve_dm_gnt[%0d]", i), dm_gnt, !exp_if_pat[i]);
         if (i > 0)
            check_eq($sformatf("starve_rv[%0d]", i), {if_rvalid, dm_rvalid},
                     exp_if_pat[i-1] ? 2'b10 : 2'b01);
         if (i == 1) check_eq("starve_rdata_dm", rdata, 32'hA000_0014);
         if (i == 5) check_eq("starve_rdata_if", rdata, 32'hA000_0015);
         $display("starve cycle %0d: if_gnt=%b dm_gnt=%b", i, if_gnt, dm_gnt);
         next_cycle;
      end

      // Halted: debug owns the port whatever sc holds
      halted = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd5;
      for (int j = 0; j < 4; j++) begin
         settle;
         check_eq($sformatf("halt_gnt[%0d]", j), {if_gnt, dm_gnt, dbg_gnt}, 3'b001);
         if (j > 0) begin
            check_eq($sformatf("halt_rv[%0d]", j), dbg_rvalid, 1);
            check_eq($sformatf("halt_rdata[%0d]", j), rdata, 32'h2802_0014);
         end
         $display("halted cycle %0d: dbg_gnt=%b if_gnt=%b", j, dbg_gnt, if_gnt);
         next_cycle;
      end
      halted = 1'b0;
      settle;
      check_eq("unhalt_gnt", {if_gnt, dm_gnt, dbg_gnt}, 3'b010);
      $display("unhalt: dm_gnt=%b dbg_gnt=%b", dm_gnt, dbg_gnt);

      // dm write and if read collide on address 12; if retries and sees new data
      next_cycle;
      dbg_req = 1'b0; dm_we = 1'b1; dm_addr = 10'd12; dm_wdata = 32'hDEAD_BEEF; if_addr = 10'd12;
      settle;
      check_eq("coll_dm_gnt", {if_gnt, dm_gnt, mem_we}, 3'b011);
      $display("collision: dm write gnt=%b", dm_gnt);
      next_cycle;
      dm_req = 1'b0; dm_we = 1'b0;
      settle;
      check_eq("coll_if_gnt", if_gnt, 1);
      check_eq("coll_no_resp", busy, 0);
      next_cycle;
      if_req = 1'b0;
      settle;
      check_eq("coll_if_rvalid", if_rvalid, 1);
      check_eq("coll_if_rdata", rdata, 32'hDEAD_BEEF);
      $display("collision: if retry rdata=%h", rdata);

      // Reset dropped after a dm read is accepted, with sc built up to 3
      next_cycle;
      dm_req = 1'b1; dm_addr = 10'd30; if_req = 1'b1; if_addr = 10'd31;
      for (int k = 0; k < 4; k++) begin
         settle;
         check_eq($sformatf("pre_rst_dm_gnt[%0d]", k), dm_gnt, 1);
         if (k < 3) next_cycle;
      end
      #1;
      rst_n = 1'b0;
      settle;
      check_eq("midrst_rvalid", {if_rvalid, dm_rvalid, dbg_rvalid, busy}, 0);
      check_eq("midrst_gnt", {if_gnt, dm_gnt, dbg_gnt, mem_en}, 0);
      check_eq("midrst_rdata", rdata, 0);
      $display("mid-op reset: dm_rvalid=%b busy=%b", dm_rvalid, busy);
      next_cycle;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         settle;
         check_eq($sformatf("post_rst_if_gnt[%0d]", k), if_gnt, (k == 4));
         check_eq($sformatf("post_rst_dm_gnt[%0d]", k), dm_gnt, (k != 4));
         if (k == 0) check_eq("post_rst_dm_rvalid", dm_rvalid, 0);
         $display("post-reset cycle %0d: if_gnt=%b dm_gnt=%b", k, if_gnt, dm_gnt);
         next_cycle;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Single-port memory arbiter for the pipe_MIPS32 core. It shares one synchronous word-addressed RAM between three requesters: instruction fetch (IF), data access (MEM stage, loads/stores), and a debug/loader port used to preload programs and inspect memory. It issues one RAM access per cycle, returns read data one cycle later with a per-requester valid, and prevents data traffic from starving instruction fetch. A deasserted `if_gnt` is the pipeline's fetch-stall indication.

## Interface
- `AW`, default 10: word address width.
- `DW`, default 32: data width.
- `STARVE_MAX`, default 4: the maximum number of consecutive data-port grants allowed while `if_req` is pending.

- `clk1`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `halted`  in  1  core HALTED flag; selects the priority mode.
- `if_req`  in  1 / `if_addr`  in  AW  fetch read request.
- `if_gnt`  out  1 / `if_rvalid`  out  1  fetch grant; fetch read data valid.
- `dm_req`, `dm_we`  in  1 / `dm_addr`  in  AW / `dm_wdata`  in  DW  data port request.
- `dm_gnt`, `dm_rvalid`  out  1  data port grant; data port read valid.
- `dbg_req`, `dbg_we`  in  1 / `dbg_addr`  in  AW / `dbg_wdata`  in  DW  debug port request.
- `dbg_gnt`, `dbg_rvalid`  out  1  debug port grant; debug port read valid.
- `rdata`  out  DW  shared read data, qualified by the `*_rvalid` outputs.
- `mem_en`, `mem_we`  out  1 / `mem_addr`  out  AW / `mem_wdata`  out  DW  RAM port.
- `mem_rdata`  in  DW  RAM read data, valid the cycle after `mem_en` with `mem_we=0`.
- `busy`  out  1  a read response is due this cycle.

## Operation
- At most one grant per cycle. Grants are combinational from the current requests and registered state. A request is accepted in the cycle its `*_gnt` is 1.
- If a requester's `req` is high and its `gnt` is low, the requester holds its request and its address/data stable.
- Priority when `halted=1`: dbg > dm > if.
- Priority when `halted=0`: dm > if > dbg, with the starvation override below.
- Starvation counter `sc`, width clog2(`STARVE_MAX`+1):
  - Increments on a cycle where dm is granted and `if_req=1`.
  - Clears on an IF grant, or on any cycle with `if_req=0`.
  - When `sc==STARVE_MAX` and `if_req=1`, IF wins that cycle over dm.
  - The override applies only when `halted=0`.
- RAM port:
  - `mem_en` = any grant.
  - `mem_addr`, `mem_we` and `mem_wdata` are taken from the granted requester; IF always reads, so `mem_we=0` for an IF grant.
  - With no grant: `mem_en=0`, and `mem_we`, `mem_addr` and `mem_wdata` are 0.
- Response tag register `rtag`, values {NONE, IF, DM, DBG}:
  - Loaded on every cycle: the granted requester's tag if the access is a read, otherwise NONE.
  - Exactly one of `if_rvalid`, `dm_rvalid`, `dbg_rvalid` follows `rtag`.
  - `busy` = (`rtag` != NONE).
- `rdata` = `mem_rdata` when `rtag` != NONE, else 0.
- Writes produce no response.
- Back-to-back accesses are allowed: a new grant can occur in the same cycle a previous read's response is presented, giving full throughput of 1 access per cycle.

## Timing
- Reset (`rst_n=0`, asynchronous): `rtag`=NONE and `sc`=0.
  - While reset is held, all `*_gnt`, `*_rvalid`, `mem_en`, `mem_we` and `busy` are 0.
  - While reset is held, `rdata`, `mem_addr` and `mem_wdata` are 0.
- Reset asserted mid-operation: a read accepted in the cycle before reset loses its response; its `rvalid` is never raised.
- Reset release: the first grant can occur in the first cycle after `rst_n` rises.
- Read latency: request accepted in cycle N → `*_rvalid`=1 and `rdata` valid in cycle N+1, for exactly one cycle.
- Write: the RAM is updated at the end of the accept cycle N. A read of the same address granted in N+1 returns the new data in N+2.
- A change of `halted` takes effect in the same cycle's arbitration. `sc` is not cleared when `halted` changes.
- If the same address is requested simultaneously by dm (write) and IF (read), only the winner is accepted. The loser is retried and sees the post-write data.

## Test plan
- Reset and idle: hold `rst_n=0` with all `req=1` → every output is 0. Release with no requests → `mem_en=0`, `busy=0`.
- Basic read/write:
  - dbg write addr 5 = 32'h28020014 with `halted=1` → `dbg_gnt=1` in cycle N.
  - dbg read addr 5 in N+1 → `dbg_rvalid=1` and `rdata`=32'h28020014 in N+2.
- Priority with `halted=0`: `if_req` and `dm_req` both high for one cycle → `dm_gnt=1`, `if_gnt=0`. IF is granted the next cycle; `rtag` sequence is DM then IF.
- Starvation: `halted=0`, dm reads continuously and `if_req` held high → dm granted 4 cycles, IF granted on the 5th, then dm resumes. Repeat → the same 4:1 pattern.
- Halted mode: `halted=1` with all three requests high → `dbg_gnt=1` every cycle. `if_gnt` stays 0 regardless of `sc`.
- Reset mid-read: IF read granted in cycle N, `rst_n` dropped during N+1 before the edge → `if_rvalid` stays 0. After release, `sc=0` and normal grants resume.
